legv8_instr_encoder: RTL and testbench

Encoder counterpart to the control decoder. It accepts symbolic LEGv8 instructions (an op selector plus register and immediate fields) over a valid/ready handshake and packs each one into a 32-bit instruction word. Each word is written into the instruction memory at sequentially incremented byte addresses. It is the program-load front end of the pipelined core: tests and bootstrap logic fill instruction memory through it before the core is released.

---
 rtl/legv8_pkg.sv | 47 ++++
 rtl/legv8_instr_encoder_if.sv | 19 +
 rtl/legv8_pack.sv | 71 +++++++
 rtl/legv8_instr_encoder.sv | 125 ++++++++++++
 tb/tb_legv8_instr_encoder.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions: op selector, opcode constants, immediate field widths
// and the load-session states used by the program-load encoder.
package legv8_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_ORR  = 4'd3,
    OP_EOR  = 4'd4,
    OP_LDUR = 4'd5,
    OP_STUR = 4'd6,
    OP_LSL  = 4'd7,
    OP_LSR  = 4'd8,
    OP_BR   = 4'd9,
    OP_CBZ  = 4'd10,
    OP_CBNZ = 4'd11,
    OP_B    = 4'd12,
    OP_BL   = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_EOR  = 11'b11001010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LSR  = 11'b11010011010;
  localparam logic [10:0] OPC_BR   = 11'b11010110000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [7:0]  OPC_CBNZ = 8'b10110101;
  localparam logic [5:0]  OPC_B    = 6'b000101;
  localparam logic [5:0]  OPC_BL   = 6'b100101;

  localparam int D_IMM_W  = 9;
  localparam int CB_IMM_W = 19;
  localparam int B_IMM_W  = 26;

endpackage

// File: rtl/legv8_instr_encoder_if.sv
// Instruction handshake plus instruction-memory write bus of the program-load encoder.
interface legv8_instr_encoder_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rd;
  logic [4:0]        rn;
  logic [4:0]        rm;
  logic [5:0]        shamt;
  logic [25:0]       imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output in_valid, op, rd, rn, rm, shamt, imm,
                  input  in_ready, imem_we, imem_addr, imem_wdata);
  modport slave  (input  in_valid, op, rd, rn, rm, shamt, imm,
                  output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/legv8_pack.sv
// Combinational LEGv8 field packer: op + fields -> 32-bit word and legality.
// With IMM_RANGE_CHECK_EN defined, also reports whether imm sign-fits its field.
module legv8_pack
  import legv8_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [5:0]  shamt,
  input  logic [25:0] imm,
`ifdef IMM_RANGE_CHECK_EN
  output logic        fits,
`endif
  output logic [31:0] word,
  output logic        legal
);

`ifdef IMM_RANGE_CHECK_EN
  logic d_fits, cb_fits;
  // Upper imm bits must replicate the field's sign bit.
  assign d_fits  = (imm[25:D_IMM_W-1]  == {(27-D_IMM_W){imm[D_IMM_W-1]}});
  assign cb_fits = (imm[25:CB_IMM_W-1] == {(27-CB_IMM_W){imm[CB_IMM_W-1]}});
`endif

  always_comb begin
    word  = '0;
    legal = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
    fits  = 1'b1;
`endif
    case (op_e'(op))
      OP_ADD:  word = {OPC_ADD, rm, 6'b0, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'b0, rn, rd};
      OP_AND:  word = {OPC_AND, rm, 6'b0, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'b0, rn, rd};
      OP_EOR:  word = {OPC_EOR, rm, 6'b0, rn, rd};
      OP_LSL:  word = {OPC_LSL, 5'b0, shamt, rn, rd};
      OP_LSR:  word = {OPC_LSR, 5'b0, shamt, rn, rd};
      OP_BR:   word = {OPC_BR, 5'b0, 6'b0, rn, 5'b0};
      OP_LDUR: begin
        word = {OPC_LDUR, imm[D_IMM_W-1:0], 2'b00, rn, rd};
`ifdef IMM_RANGE_CHECK_EN
        fits = d_fits;
`endif
      end
      OP_STUR: begin
        word = {OPC_STUR, imm[D_IMM_W-1:0], 2'b00, rn, rd};
`ifdef IMM_RANGE_CHECK_EN
        fits = d_fits;
`endif
      end
      OP_CBZ: begin
        word = {OPC_CBZ, imm[CB_IMM_W-1:0], rd};
`ifdef IMM_RANGE_CHECK_EN
        fits = cb_fits;
`endif
      end
      OP_CBNZ: begin
        word = {OPC_CBNZ, imm[CB_IMM_W-1:0], rd};
`ifdef IMM_RANGE_CHECK_EN
        fits = cb_fits;
`endif
      end
      OP_B:    word = {OPC_B, imm[B_IMM_W-1:0]};
      OP_BL:   word = {OPC_BL, imm[B_IMM_W-1:0]};
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/legv8_instr_encoder.sv
// LEGv8 program-load encoder: packs handshaked instructions into sequential imem writes.
// Optional IMM_RANGE_CHECK_EN adds immediate sign-fit checking and the err_range flag.
module legv8_instr_encoder
  import legv8_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  legv8_instr_encoder_if.slave bus,
  output logic [ADDR_W-1:0] word_count,
  output logic              busy,
  output logic              load_done,
  output logic              err_illegal,
`ifdef IMM_RANGE_CHECK_EN
  output logic              err_range,
`endif
  output logic              err_full
);

  load_state_e       state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic [31:0]       word;
  logic              legal;
  logic              write_ok;
  logic              full;
  logic              accept;

`ifdef IMM_RANGE_CHECK_EN
  logic fits;
`endif

  legv8_pack u_pack (
    .op    (bus.op),
    .rd    (bus.rd),
    .rn    (bus.rn),
    .rm    (bus.rm),
    .shamt (bus.shamt),
    .imm   (bus.imm),
`ifdef IMM_RANGE_CHECK_EN
    .fits  (fits),
`endif
    .word  (word),
    .legal (legal)
  );

`ifdef IMM_RANGE_CHECK_EN
  assign write_ok = legal && fits;
`else
  assign write_ok = legal;
`endif

  assign full           = (word_count == ADDR_W'(DEPTH));
  assign bus.in_ready   = (state == ST_LOAD) && !full && !start;
  assign accept         = bus.in_valid && bus.in_ready;
  assign busy           = (state == ST_LOAD);
  assign load_done      = (state == ST_DONE);
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = waddr_q;
  assign bus.imem_wdata = wdata_q;

  // start outranks finish, so a start+finish cycle restarts the session.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_LOAD;
      ST_LOAD: begin
        if (start)       state_nx = ST_LOAD;
        else if (finish) state_nx = ST_DONE;
      end
      ST_DONE: if (start) state_nx = ST_LOAD;
      default: state_nx = ST_IDLE;
    endcase
  end

  // A write captured last cycle is already in we_q/waddr_q, so start never cancels it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      addr_q      <= '0;
      word_count  <= '0;
      err_illegal <= 1'b0;
      err_full    <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      err_range   <= 1'b0;
`endif
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state <= state_nx;
      we_q  <= accept && write_ok;
      if (accept && write_ok) begin
        waddr_q <= addr_q;
        wdata_q <= word;
      end
      if (start) begin
        addr_q      <= '0;
        word_count  <= '0;
        err_illegal <= 1'b0;
        err_full    <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
        err_range   <= 1'b0;
`endif
      end else begin
        if (accept && write_ok) begin
          addr_q     <= addr_q + ADDR_W'(4);
          word_count <= word_count + ADDR_W'(1);
        end
        if (accept && !legal) err_illegal <= 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        if (accept && legal && !fits) err_range <= 1'b1;
`endif
        if ((state == ST_LOAD) && bus.in_valid && full) err_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Bench for legv8_instr_encoder: encoding table, hand-written corner sequences and
// randomized sessions checked against a behavioural model (DEPTH=4 instance).
module tb_legv8_instr_encoder;
  localparam int ADDR_W = 10;
  localparam int DEP    = 4;

  logic clock = 1'b0;
  logic reset, start, finish;
  logic [ADDR_W-1:0] word_count;
  logic busy, load_done, err_illegal, err_full;
`ifdef IMM_RANGE_CHECK_EN
  logic err_range;
`endif

  int vectors = 0;
  int miscompares = 0;

  legv8_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  legv8_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEP)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .finish      (finish),
    .bus         (bus),
    .word_count  (word_count),
    .busy        (busy),
    .load_done   (load_done),
    .err_illegal (err_illegal),
`ifdef IMM_RANGE_CHECK_EN
    .err_range   (err_range),
`endif
    .err_full    (err_full)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [5:0]  shamt;
    logic [25:0] imm;
    logic [31:0] exp_word;
    logic        exp_legal;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.op = '0; bus.rd = '0; bus.rn = '0; bus.rm = '0; bus.shamt = '0; bus.imm = '0;
    start = 1'b0;
    finish = 1'b0;
  endtask

  task automatic drive(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                       input logic [4:0] m, input logic [5:0] sh, input logic [25:0] im);
    bus.in_valid = 1'b1;
    bus.op = o; bus.rd = d; bus.rn = n; bus.rm = m; bus.shamt = sh; bus.imm = im;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " we"}, 64'(bus.imem_we), 64'd0);
    chk({nm, " addr"}, 64'(bus.imem_addr), 64'd0);
    chk({nm, " wdata"}, 64'(bus.imem_wdata), 64'd0);
    chk({nm, " wc"}, 64'(word_count), 64'd0);
    chk({nm, " flags"}, 64'({busy, load_done, err_illegal, err_full}), 64'd0);
  endtask

  // Reference encoding from the instruction-format rules, using plain arithmetic.
  function automatic logic [31:0] ref_enc(input int o, input int d, input int n, input int m,
                                          input int sh, input logic [25:0] im);
    longint w;
    longint imv;
    imv = longint'(im);
    case (o)
      0:  w = 64'h458 * (1 << 21) + m * 65536 + n * 32 + d;
      1:  w = 64'h658 * (1 << 21) + m * 65536 + n * 32 + d;
      2:  w = 64'h450 * (1 << 21) + m * 65536 + n * 32 + d;
      3:  w = 64'h550 * (1 << 21) + m * 65536 + n * 32 + d;
      4:  w = 64'h650 * (1 << 21) + m * 65536 + n * 32 + d;
      5:  w = 64'h7C2 * (1 << 21) + (imv % 512) * 4096 + n * 32 + d;
      6:  w = 64'h7C0 * (1 << 21) + (imv % 512) * 4096 + n * 32 + d;
      7:  w = 64'h69B * (1 << 21) + sh * 1024 + n * 32 + d;
      8:  w = 64'h69A * (1 << 21) + sh * 1024 + n * 32 + d;
      9:  w = 64'h6B0 * (1 << 21) + n * 32;
      10: w = 64'hB4 * (1 << 24) + (imv % (1 << 19)) * 32 + d;
      11: w = 64'hB5 * (1 << 24) + (imv % (1 << 19)) * 32 + d;
      12: w = 64'h05 * (1 << 26) + imv;
      13: w = 64'h25 * (1 << 26) + imv;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic bit ref_fits(input int o, input logic [25:0] im);
    int v;
    v = int'($signed(im));
`ifdef IMM_RANGE_CHECK_EN
    if (o == 5 || o == 6)   return (v >= -256) && (v <= 255);
    if (o == 10 || o == 11) return (v >= -(1 << 18)) && (v < (1 << 18));
`endif
    return 1'b1;
  endfunction

  // Behavioural model state for the random phase.
  int   m_mode;      // 0 idle, 1 loading, 2 done
  int   m_cnt;
  bit   m_we, m_eill, m_efull, m_erng;
  int   m_addr;
  logic [31:0] m_wdata;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_we = 0; m_eill = 0; m_efull = 0; m_erng = 0;
    m_addr = 0; m_wdata = '0;
  endtask

  initial begin
    tbl[0] = '{4'd0,  5'd3, 5'd1,  5'd2, 6'd0, 26'd0,        32'h8B020023, 1'b1};
    tbl[1] = '{4'd1,  5'd0, 5'd0,  5'd0, 6'd0, 26'd0,        32'hCB000000, 1'b1};
    tbl[2] = '{4'd5,  5'd5, 5'd2,  5'd0, 6'd0, 26'd8,        32'hF8408045, 1'b1};
    tbl[3] = '{4'd6,  5'd7, 5'd31, 5'd0, 6'd0, 26'h3FFFFFF,  32'hF81FF3E7, 1'b1};
    tbl[4] = '{4'd7,  5'd1, 5'd2,  5'd0, 6'd3, 26'd0,        32'hD3600C41, 1'b1};
    tbl[5] = '{4'd9,  5'd0, 5'd30, 5'd0, 6'd0, 26'd0,        32'hD60003C0, 1'b1};
    tbl[6] = '{4'd10, 5'd1, 5'd0,  5'd0, 6'd0, 26'h3FFFFFE,  32'hB4FFFFC1, 1'b1};
    tbl[7] = '{4'd12, 5'd0, 5'd0,  5'd0, 6'd0, 26'd3,        32'h14000003, 1'b1};
    tbl[8] = '{4'd13, 5'd0, 5'd0,  5'd0, 6'd0, 26'd3,        32'h94000003, 1'b1};
    tbl[9] = '{4'd15, 5'd1, 5'd1,  5'd1, 6'd0, 26'd0,        32'h00000000, 1'b0};

    idle_in();
    reset = 1'b1;
    repeat (2) tick();
    chk_all_zero("reset");
    chk("reset in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("finish in idle ignored", 64'({busy, load_done}), 64'd0);

    // Encoding table: one instruction per fresh session.
    for (int i = 0; i < 10; i++) begin
      do_start();
      drive(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].shamt, tbl[i].imm);
      #1 chk($sformatf("tbl%0d ready", i), 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("tbl%0d we", i), 64'(bus.imem_we), 64'(tbl[i].exp_legal));
      if (tbl[i].exp_legal) begin
        chk($sformatf("tbl%0d wdata", i), 64'(bus.imem_wdata), 64'(tbl[i].exp_word));
        chk($sformatf("tbl%0d addr", i), 64'(bus.imem_addr), 64'd0);
      end
      chk($sformatf("tbl%0d wc", i), 64'(word_count), 64'(tbl[i].exp_legal));
      chk($sformatf("tbl%0d err_illegal", i), 64'(err_illegal), 64'(!tbl[i].exp_legal));
    end

    // LDUR then CBZ back-to-back.
    do_start();
    drive(4'd5, 5'd5, 5'd2, 5'd0, 6'd0, 26'd8);
    tick();
    drive(4'd10, 5'd1, 5'd0, 5'd0, 6'd0, 26'h3FFFFFE);
    chk("b2b w0 we", 64'(bus.imem_we), 64'd1);
    chk("b2b w0 wdata", 64'(bus.imem_wdata), 64'hF8408045);
    chk("b2b w0 addr", 64'(bus.imem_addr), 64'h000);
    tick();
    bus.in_valid = 1'b0;
    chk("b2b w1 we", 64'(bus.imem_we), 64'd1);
    chk("b2b w1 wdata", 64'(bus.imem_wdata), 64'hB4FFFFC1);
    chk("b2b w1 addr", 64'(bus.imem_addr), 64'h004);
    chk("b2b wc", 64'(word_count), 64'd2);

    // B, then BL with finish in the same cycle.
    do_start();
    drive(4'd12, 5'd0, 5'd0, 5'd0, 6'd0, 26'd3);
    tick();
    drive(4'd13, 5'd0, 5'd0, 5'd0, 6'd0, 26'd3);
    finish = 1'b1;
    chk("B wdata", 64'(bus.imem_wdata), 64'h14000003);
    tick();
    idle_in();
    #1;
    chk("BL we", 64'(bus.imem_we), 64'd1);
    chk("BL wdata", 64'(bus.imem_wdata), 64'h94000003);
    chk("BL addr", 64'(bus.imem_addr), 64'h004);
    chk("finish load_done", 64'({load_done, busy}), 64'b10);
    chk("finish in_ready", 64'(bus.in_ready), 64'd0);
    tick();

    // Fill to DEPTH with five valid ops.
    begin
      int nwr;
      nwr = 0;
      do_start();
      for (int i = 0; i < 6; i++) begin
        if (i < 5) drive(4'd0, 5'(i), 5'd0, 5'd0, 6'd0, 26'd0);
        else bus.in_valid = 1'b0;
        #1;
        chk($sformatf("full ready%0d", i), 64'(bus.in_ready), 64'(i < DEP));
        tick();
        if (bus.imem_we) begin
          chk($sformatf("full addr%0d", nwr), 64'(bus.imem_addr), 64'(nwr * 4));
          nwr++;
        end
      end
      chk("full writes", 64'(nwr), 64'(DEP));
      chk("full wc", 64'(word_count), 64'(DEP));
      chk("full err_full", 64'(err_full), 64'd1);
      do_start();
      chk("start clears err_full", 64'(err_full), 64'd0);
      chk("start clears wc", 64'(word_count), 64'd0);
    end

    // Illegal op followed by ADD.
    do_start();
    drive(4'd15, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
    tick();
    drive(4'd0, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
    chk("illegal no write", 64'(bus.imem_we), 64'd0);
    chk("illegal flag", 64'(err_illegal), 64'd1);
    chk("illegal wc", 64'(word_count), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("post-illegal ADD", 64'({bus.imem_we, bus.imem_wdata, 22'(bus.imem_addr)}),
        64'({1'b1, 32'h8B020023, 22'd0}));

    // start during a pending write: write completes at its old address.
    do_start();
    drive(4'd1, 5'd0, 5'd0, 5'd0, 6'd0, 26'd0);
    tick();
    drive(4'd0, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
    tick();
    bus.in_valid = 1'b1;
    start = 1'b1;
    #1 chk("start blocks accept", 64'(bus.in_ready), 64'd0);
    chk("pending survives start", 64'({bus.imem_we, 22'(bus.imem_addr)}), 64'({1'b1, 22'd4}));
    tick();
    idle_in();
    chk("after start we", 64'(bus.imem_we), 64'd0);
    chk("after start wc", 64'(word_count), 64'd0);

    // Reset in the cycle after an acceptance.
    drive(4'd0, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_all_zero("reset after accept");
    // Reset in the same cycle as an acceptance drops the pending write.
    do_start();
    drive(4'd0, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_in();
    chk_all_zero("reset with accept");

    // Randomized sessions against the behavioural model.
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit  s, f, v, rdy, acc, ok;
      int  o;
      s = ($urandom_range(0, 15) == 0);
      f = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 1) == 1);
      o = $urandom_range(0, 15);
      start = s;
      finish = f;
      bus.in_valid = v;
      bus.op = 4'(o);
      bus.rd = 5'($urandom);
      bus.rn = 5'($urandom);
      bus.rm = 5'($urandom);
      bus.shamt = 6'($urandom);
      bus.imm = ($urandom_range(0, 1) == 1) ? 26'($urandom) : 26'($signed(8'($urandom)));
      #1;
      rdy = (m_mode == 1) && (m_cnt < DEP) && !s;
      chk("rnd in_ready", 64'(bus.in_ready), 64'(rdy));
      chk("rnd we", 64'(bus.imem_we), 64'(m_we));
      chk("rnd addr", 64'(bus.imem_addr), 64'(m_addr));
      chk("rnd wdata", 64'(bus.imem_wdata), 64'(m_wdata));
      chk("rnd wc", 64'(word_count), 64'(m_cnt));
      chk("rnd state", 64'({busy, load_done}), 64'({m_mode == 1, m_mode == 2}));
      chk("rnd errs", 64'({err_illegal, err_full}), 64'({m_eill, m_efull}));
`ifdef IMM_RANGE_CHECK_EN
      chk("rnd err_range", 64'(err_range), 64'(m_erng));
`endif
      acc = v && rdy;
      ok  = (o <= 13) && ref_fits(o, bus.imm);
      m_we = acc && ok;
      if (acc && ok) begin
        m_addr  = m_cnt * 4;
        m_wdata = ref_enc(o, int'(bus.rd), int'(bus.rn), int'(bus.rm), int'(bus.shamt), bus.imm);
      end
      if (s) begin
        m_cnt = 0; m_eill = 0; m_efull = 0; m_erng = 0;
      end else begin
        if (v && m_mode == 1 && m_cnt == DEP) m_efull = 1;
        if (acc && o > 13) m_eill = 1;
        if (acc && o <= 13 && !ok) m_erng = 1;
        if (acc && ok) m_cnt++;
      end
      if (s) m_mode = 1;
      else if (m_mode == 1 && f) m_mode = 2;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
